// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
//   Turns a stream of PS/2 set-2 scancode bytes into game commands.
//   A prefix decoder FSM (E0 / F0 handling) classifies each byte as a make or
//   a break. Five keys are tracked: held mask plus one pending press bit per key.
//   A registered priority arbiter presents one command at a time on a
//   valid/ready handshake.
//
//   Optional feature: define KEY_AUTO_REPEAT_EN to let LEFT, RIGHT and DOWN
//   auto-repeat while held (first repeat after REPEAT_DELAY cycles, then every
//   REPEAT_RATE cycles). If it is not defined, no repeat counters exist.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   frame_valid  one-cycle strobe, frame_data carries a new scancode byte
//   frame_data   received set-2 scancode byte
//   cmd_ready    consumer accepts cmd this cycle
//   cmd_valid    a command is presented
//   cmd          1=LEFT 2=RIGHT 3=DOWN 4=ROTATE 5=DROP, 0=none
//   held         held-key mask {DROP, ROTATE, DOWN, RIGHT, LEFT}
//
// Decoder states
//   state    | meaning
//   IDLE     | no prefix seen, next byte is a make or a prefix
//   EXT      | E0 seen, next byte is an extended make or F0
//   BRK      | F0 seen, next byte is a break
//   EXT_BRK  | E0 F0 seen, next byte is an extended break
module key_cmd_scheduler #(
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_RATE    = 5_000_000,
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  input  logic [7:0] frame_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [4:0] held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;
  localparam logic [31:0] TO_LOAD  = 32'(PREFIX_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_to_cnt;
  logic        w_dec_en;
  logic        w_dec_ext;
  logic        w_dec_brk;
  logic [4:0]  w_key;
  logic [4:0]  w_make;
  logic [4:0]  w_brk;
  logic [4:0]  w_new_press;
  logic [4:0]  w_rep_set;
  logic [4:0]  w_clr;
  logic [2:0]  w_pick;
  logic [4:0]  r_held;
  logic [4:0]  r_pend;
  logic        r_cmd_valid;
  logic [2:0]  r_cmd;

  // ---------------- decoder FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dec_en    = 1'b0;
    w_dec_ext   = 1'b0;
    w_dec_brk   = 1'b0;
    if (frame_valid) begin
      case (r_state)
        IDLE: begin
          if (frame_data == BYTE_EXT)      w_state_nxt = EXT;
          else if (frame_data == BYTE_BRK) w_state_nxt = BRK;
          else                             w_dec_en    = 1'b1;
        end
        EXT: begin
          if (frame_data == BYTE_BRK) w_state_nxt = EXT_BRK;
          else begin
            w_dec_en    = 1'b1;
            w_dec_ext   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        BRK: begin
          w_dec_en    = 1'b1;
          w_dec_brk   = 1'b1;
          w_state_nxt = IDLE;
        end
        EXT_BRK: begin
          w_dec_en    = 1'b1;
          w_dec_ext   = 1'b1;
          w_dec_brk   = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_to_cnt == 32'd0) begin
      // prefix went stale: drop it
      w_state_nxt = IDLE;
    end
  end

  // Reloaded on every byte; only meaningful while a prefix is outstanding.
  // Idle cycle k after a prefix sees TO_LOAD-(k-1), so the FSM leaves on
  // the PREFIX_TIMEOUT-th idle cycle.
  always_ff @(posedge clk) begin
    if (rst)                                    r_to_cnt <= 32'd0;
    else if (frame_valid)                       r_to_cnt <= TO_LOAD;
    else if (r_state != IDLE && r_to_cnt != 0)  r_to_cnt <= r_to_cnt - 32'd1;
  end

  // ---------------- key map ----------------
  always_comb begin
    w_key = 5'b0;
    if (w_dec_en) begin
      case ({w_dec_ext, frame_data})
        9'h029:  w_key[4] = 1'b1;
        9'h175:  w_key[3] = 1'b1;
        9'h172:  w_key[2] = 1'b1;
        9'h174:  w_key[1] = 1'b1;
        9'h16B:  w_key[0] = 1'b1;
        default: w_key    = 5'b0;
      endcase
    end
  end

  assign w_make      = w_key & {5{~w_dec_brk}};
  assign w_brk       = w_key & {5{w_dec_brk}};
  // typematic makes of an already-held key fall out here
  assign w_new_press = w_make & ~r_held;

  // ---------------- auto-repeat ----------------
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [31:0] REP_DELAY_LOAD = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] REP_RATE_LOAD  = 32'(REPEAT_RATE - 1);

  // only LEFT, RIGHT, DOWN (bits 0..2) repeat
  logic [31:0] r_rep_cnt [3];

  always_comb begin
    w_rep_set = 5'b0;
    for (int i = 0; i < 3; i++) begin
      if (r_held[i] && !w_brk[i] && r_rep_cnt[i] == 32'd0) w_rep_set[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_rep_cnt[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_brk[i])            r_rep_cnt[i] <= 32'd0;
        else if (w_new_press[i]) r_rep_cnt[i] <= REP_DELAY_LOAD;
        else if (r_held[i])      r_rep_cnt[i] <= (r_rep_cnt[i] == 32'd0) ?
                                                 REP_RATE_LOAD : r_rep_cnt[i] - 32'd1;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY == 0) ^ (REPEAT_RATE == 0);
  assign w_rep_set    = 5'b0;
`endif

  // ---------------- held / pending ----------------
  // Granted bit clears on the handshake; a set in the same cycle wins.
  assign w_clr = (r_cmd_valid && cmd_ready) ? (5'd1 << (r_cmd - 3'd1)) : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= 5'b0;
      r_pend <= 5'b0;
    end else begin
      r_held <= (r_held | w_make) & ~w_brk;
      r_pend <= (r_pend & ~w_clr) | w_new_press | w_rep_set;
    end
  end

  // ---------------- arbiter ----------------
  // later assignments override: DROP > ROTATE > DOWN > LEFT > RIGHT
  always_comb begin
    w_pick = 3'd0;
    if (r_pend[1]) w_pick = 3'd2;
    if (r_pend[0]) w_pick = 3'd1;
    if (r_pend[2]) w_pick = 3'd3;
    if (r_pend[3]) w_pick = 3'd4;
    if (r_pend[4]) w_pick = 3'd5;
  end

  // A presented command is frozen until accepted; after acceptance valid
  // drops for one cycle so the cleared pending bit is visible to arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= 3'd0;
    end else if (r_cmd_valid) begin
      if (cmd_ready) begin
        r_cmd_valid <= 1'b0;
        r_cmd       <= 3'd0;
      end
    end else if (|r_pend) begin
      r_cmd_valid <= 1'b1;
      r_cmd       <= w_pick;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign held      = r_held;

endmodule

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter REPEAT_DELAY, default 25_000_000, is the number of clk cycles a key is held before its first auto-repeat.
REQ-002 Parameter REPEAT_RATE, default 5_000_000, is the number of clk cycles between successive auto-repeats.
REQ-003 Parameter PREFIX_TIMEOUT, default 1_000_000, is the maximum number of clk cycles allowed between a prefix byte and the byte that follows it.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 frame_valid  input  1  one-cycle strobe; frame_data holds a new scancode byte.
REQ-007 frame_data  input  8  received set-2 scancode byte.
REQ-008 cmd_ready  input  1  game logic accepts cmd this cycle.
REQ-009 cmd_valid  output  1  a command is presented.
REQ-010 cmd  output  3  command code: 1=LEFT, 2=RIGHT, 3=DOWN, 4=ROTATE, 5=DROP, 0=none.
REQ-011 held  output  5  held-key mask, bits [4:0] = DROP, ROTATE, DOWN, RIGHT, LEFT.

Function
REQ-012 The decoder FSM SHALL have exactly the states IDLE, EXT, BRK and EXT_BRK, and SHALL evaluate only cycles with frame_valid=1.
REQ-013 From IDLE: byte E0 SHALL go to EXT, byte F0 SHALL go to BRK, and any other byte SHALL be decoded as a make and SHALL stay in IDLE.
REQ-014 From EXT: byte F0 SHALL go to EXT_BRK, and any other byte SHALL be decoded as an extended make and SHALL go to IDLE.
REQ-015 From BRK the byte SHALL be decoded as a break and the FSM SHALL go to IDLE; from EXT_BRK the byte SHALL be decoded as an extended break and the FSM SHALL go to IDLE.
REQ-016 The key map SHALL be exactly: 29 = DROP (non-extended); E0 75 = ROTATE; E0 72 = DOWN; E0 6B = LEFT; E0 74 = RIGHT; all other codes SHALL be ignored.
REQ-017 In any non-IDLE state, if PREFIX_TIMEOUT cycles elapse without frame_valid, the FSM SHALL return to IDLE and discard the prefix.
REQ-018 A make of a key whose held bit is 0 SHALL set that held bit and that key's pending bit, and SHALL restart that key's repeat counter.
REQ-019 A make of a key whose held bit is already 1 (keyboard typematic) SHALL be ignored.
REQ-020 A break SHALL clear the key's held bit only; a pending press SHALL still be issued.
REQ-021 The arbiter SHALL grant the highest-priority pending bit in the order DROP > ROTATE > DOWN > LEFT > RIGHT.
REQ-022 cmd_valid SHALL assert the cycle after a pending bit becomes set, with cmd registered.
REQ-023 While cmd_valid=1 and cmd_ready=0, cmd SHALL hold stable and SHALL not be re-arbitrated.
REQ-024 On cmd_valid and cmd_ready, the granted pending bit SHALL clear, and the next grant SHALL appear no earlier than the following cycle.
REQ-025 Pending bits SHALL coalesce, with at most one outstanding press per key.
REQ-026 If a pending bit is set and granted in the same cycle, the set SHALL win and the bit SHALL remain pending.
REQ-027 Reset values SHALL be: cmd_valid=0, cmd=0, held=0, all pending bits 0, all counters 0, FSM in IDLE.

Reset
REQ-028 rst SHALL take priority over every input, including frame_valid and cmd_ready in the same cycle.
REQ-029 rst asserted mid-operation SHALL drop any presented cmd without a handshake.

Configuration
REQ-030 When KEY_AUTO_REPEAT_EN is defined, LEFT, RIGHT and DOWN SHALL set their pending bit REPEAT_DELAY cycles after make while held, then every REPEAT_RATE cycles.
REQ-031 ROTATE and DROP SHALL never auto-repeat, whether or not KEY_AUTO_REPEAT_EN is defined.
REQ-032 A break SHALL stop auto-repeat and clear that key's counter.
REQ-033 When KEY_AUTO_REPEAT_EN is undefined, no repeat counters SHALL exist, and each make SHALL issue exactly one command.

Verification
REQ-034 Scenario: bytes E0,6B with cmd_ready=1 -> cmd_valid for one cycle with cmd=1, held=00001.
REQ-035 Scenario: bytes 29 and E0,75 then cmd_ready=1 -> cmd=5 first, then cmd=4.
REQ-036 Scenario: cmd_ready=0 for 10 cycles after a make of E0,74 -> cmd=2 held stable for 10 cycles, issued once, with no duplicate.
REQ-037 Scenario: E0,72 then 11 further E0,72 bytes (typematic) then E0,F0,72 -> exactly one DOWN command (macro off), and held[2] returns to 0.
REQ-038 Scenario: E0 then PREFIX_TIMEOUT idle cycles then 6B -> no command issued.
REQ-039 Scenario: with KEY_AUTO_REPEAT_EN and REPEAT_DELAY=100, REPEAT_RATE=20, hold LEFT for 160 cycles -> LEFT pending at cycles 0, 100, 120 and 140 after the make; rst in mid-hold -> all outputs 0 on the next cycle.
